mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Round-robin arbiter that shares one `WIDTH`-bit 4:1 data mux between four requesters and drives its select. Each requester offers a valid/ready stream of packet beats, terminated by a `last` bit. A grant is locked for the whole packet; it is released only on the beat carrying `last`. The block sits in front of a single downstream consumer (bus, register file port or ALU operand), with the existing parameterised `mux_4x1` as its datapath.

## Interface
Parameters:
- `WIDTH`, default 2: data width of each requester input and of the output.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-low.
- `in0`, `in1`, `in2`, `in3`, in, `WIDTH` each: requester data.
- `req_valid`, in, 4: per-requester beat valid. Bit i belongs to `in<i>`.
- `req_last`, in, 4: per-requester end-of-packet flag. Qualified by the matching `req_valid` bit.
- `req_ready`, out, 4: per-requester beat accepted.
- `out_data`, out, `WIDTH`: muxed data.
- `out_valid`, out, 1: output beat valid.
- `out_last`, out, 1: output end-of-packet.
- `out_ready`, in, 1: consumer accepts a beat.
- `grant`, out, 4: one-hot current owner. All zeros when idle.
- `sel`, out, 2: registered mux select, visible for debug.

## Operation
- Two-state FSM with states IDLE and BUSY.
- Registers:
  - `sel` (2 bits).
  - `ptr` (2 bits): highest-priority requester for the next arbitration.
- IDLE:
  - `grant`=0, `out_valid`=0, `req_ready`=0.
  - If any `req_valid` bit is set, pick the first set bit scanning `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4).
  - Register the winner into `sel` and go to BUSY.
  - No beat transfers in IDLE.
- BUSY:
  - `grant` = onehot(`sel`).
  - `out_data` = `in<sel>` through the mux.
  - `out_valid` = `req_valid[sel]`; `out_last` = `req_last[sel]` & `req_valid[sel]`.
  - `req_ready[sel]` = `out_ready`. All other `req_ready` bits are 0.
- Transfer: a beat moves when `out_valid` & `out_ready`.
  - If a transfer has `out_last`=1: set `ptr` ← `sel`+1 (mod 4) and go to IDLE.
  - Otherwise stay in BUSY.
- Owner drops `req_valid` mid-packet: the grant is held and `out_valid`=0. Other requesters wait; there is no timeout.
- Non-owner requests while BUSY are ignored until release. Requesters must hold `req_valid` and data stable until they see ready.
- Fairness: a requester waits at most 3 packets from other requesters before it is granted.
- Reset (`reset`=0 at a clock edge), including mid-packet:
  - state=IDLE, `sel`=0, `ptr`=0.
  - `grant`=0, `req_ready`=0, `out_valid`=0, `out_last`=0.
  - `out_data` = `in0`, as the mux output with `sel`=0.
  - The packet in flight is abandoned. The requester must restart it.

## Timing
- Arbitration latency: requests seen in IDLE on edge N give BUSY and `grant` valid after edge N. The first beat can transfer in cycle N+1.
- Throughput: one beat per cycle inside a packet.
- Packet boundary: exactly one IDLE bubble between packets. A `last` transfer at edge M means the next grant is decided at edge M+1.
- Single-beat packets: 1 beat per 2 cycles.
- `out_valid`, `out_data`, `out_last` and `req_ready` are combinational from `req_valid`, `req_last`, `in<i>` and `out_ready`, gated by registered state. No combinational path runs from `out_ready` to `out_valid`.
- `grant` and `sel` are purely registered.

## Structure
- Shared header/package holds:
  - the state encodings `ST_IDLE`=1'b0 and `ST_BUSY`=1'b1;
  - `NUM_REQ`=4;
  - the select width constant 2.
- Sub-module: one instance of `mux_4x1 #(WIDTH)` for `out_data`. The same module is used for `out_last`, instantiated with width 1 and the `req_last` bits as inputs.
- Priority-rotate logic, FSM and `ptr` live in this block. Target 150–250 lines of RTL.

## Test plan
- Reset then idle: hold `reset`=0 for 2 cycles with all `req_valid`=0. Required: `grant`=0000, `out_valid`=0, `sel`=00, `req_ready`=0000.
- Single requester: `req_valid`=0100, `in2`=2'b11, 3-beat packet with `last` on beat 3, `out_ready`=1. Required:
  - `grant`=0100 one cycle after the request;
  - 3 consecutive transfers with `out_data`=11 and `out_last` only on the third;
  - IDLE on the next cycle, `ptr`=3.
- Round-robin: all four requesters continuously offer 1-beat packets, starting from `ptr`=0. Required: grant order 0, 1, 2, 3, 0, with one IDLE cycle between grants.
- Lock and backpressure: owner 1 in mid-packet, `out_ready`=0 for 3 cycles while `req_valid`=1111. Required:
  - `grant` stays 0010 and `req_ready`=0000;
  - no transfers;
  - transfers resume when `out_ready`=1.
- Owner stall: owner 3 drops `req_valid` mid-packet for 2 cycles while requester 0 requests. Required: `out_valid`=0, `grant` stays 1000, and requester 0 is granted only after requester 3's `last` beat.
- Reset mid-packet: assert `reset`=0 during beat 2 of a packet from requester 2. Required: next cycle `grant`=0000, `ptr`=0. With `req_valid`=0110, requester 1 is granted next.

Source files
------------

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants, FSM encoding and the rotating-priority pick for mux_rr_arbiter.
package mux_rr_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // First set request bit scanning ptr, ptr+1, ... (mod NUM_REQ).
    // The downward loop lets the lowest offset win by assigning last.
    function automatic logic [SEL_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [SEL_W-1:0]   ptr
    );
        logic [SEL_W-1:0] idx;
        rr_pick = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ptr + SEL_W'(k);
            if (req[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux_4x1.sv
// Parameterised 4:1 data multiplexer used as the arbiter datapath.
module mux_4x1 #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        out = in0;
        case (sel)
            2'd1:    out = in1;
            2'd2:    out = in2;
            2'd3:    out = in3;
            default: out = in0;
        endcase
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter with packet-locked grants, steering a shared 4:1 mux
// between four valid/ready requesters and one downstream consumer.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   in0,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    input  logic [WIDTH-1:0]   in3,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [NUM_REQ-1:0] req_last,
    output logic [NUM_REQ-1:0] req_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    output logic               out_last,
    input  logic               out_ready,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   sel
);

    state_t           state_reg, state_next;
    logic [SEL_W-1:0] sel_reg, sel_next;
    logic [SEL_W-1:0] ptr_reg, ptr_next;
    logic             busy;
    logic             mux_last;
    logic             xfer;

    assign busy = (state_reg == ST_BUSY);

    mux_4x1 #(.WIDTH(WIDTH)) u_data_mux (
        .in0 (in0),
        .in1 (in1),
        .in2 (in2),
        .in3 (in3),
        .sel (sel_reg),
        .out (out_data)
    );

    mux_4x1 #(.WIDTH(1)) u_last_mux (
        .in0 (req_last[0]),
        .in1 (req_last[1]),
        .in2 (req_last[2]),
        .in3 (req_last[3]),
        .sel (sel_reg),
        .out (mux_last)
    );

    // out_valid depends only on req_valid and registered state, never on out_ready.
    assign out_valid = busy & req_valid[sel_reg];
    assign out_last  = out_valid & mux_last;
    assign xfer      = out_valid & out_ready;
    assign sel       = sel_reg;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign grant[gi]     = busy && (sel_reg == SEL_W'(gi));
            assign req_ready[gi] = grant[gi] & out_ready;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            sel_reg   <= '0;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            ptr_reg   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (|req_valid) begin
                    sel_next   = rr_pick(req_valid, ptr_reg);
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Grant is released only by the accepted last beat.
                if (xfer && out_last) begin
                    ptr_next   = sel_reg + 2'd1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed and randomized checks of mux_rr_arbiter against a packet-level model.
module tb_mux_rr_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] din [4];
    logic [3:0] req_valid, req_last, req_ready, grant;
    logic [1:0] out_data, sel;
    logic       out_valid, out_last, out_ready;

    int total  = 0;
    int passed = 0;
    int cyc    = 0;

    mux_rr_arbiter #(.WIDTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in0       (din[0]),
        .in1       (din[1]),
        .in2       (din[2]),
        .in3       (din[3]),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .grant     (grant),
        .sel       (sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Packet-level model: owner (-1 when idle), last granted index and priority pointer.
    int m_owner = -1;
    int m_sel   = 0;
    int m_ptr   = 0;

    initial begin
        logic [3:0] e_grant, e_ready;
        logic       e_valid, e_last;
        int         w;
        forever begin
            @(negedge clk);
            e_grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
            e_valid = (m_owner >= 0) && req_valid[m_owner];
            e_last  = e_valid && req_last[m_owner];
            e_ready = (m_owner >= 0 && out_ready) ? 4'(1 << m_owner) : 4'b0;
            chk("m_grant", 8'(grant), 8'(e_grant));
            chk("m_sel", 8'(sel), 8'(m_sel));
            chk("m_out_valid", 8'(out_valid), 8'(e_valid));
            chk("m_out_last", 8'(out_last), 8'(e_last));
            chk("m_req_ready", 8'(req_ready), 8'(e_ready));
            chk("m_out_data", 8'(out_data), 8'(din[m_sel]));
            if (!reset) begin
                m_owner = -1;
                m_sel   = 0;
                m_ptr   = 0;
            end else if (m_owner < 0) begin
                if (req_valid != 4'b0) begin
                    w = m_ptr;
                    for (int k = 3; k >= 0; k--)
                        if (req_valid[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
                    m_owner = w;
                    m_sel   = w;
                end
            end else if (req_valid[m_owner] && out_ready && req_last[m_owner]) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
            end
        end
    end

    initial begin
        logic [3:0] rr_exp [9];
        int         beats [4];
        logic [3:0] acc;
        logic       rst_now;

        rr_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                   4'b0000, 4'b1000, 4'b0000, 4'b0001};
        reset = 1'b0; req_valid = '0; req_last = '0; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) din[i] = '0;

        // Reset then idle
        tick(); tick();
        chk("rst_grant", 8'(grant), 8'h0);
        chk("rst_out_valid", 8'(out_valid), 8'h0);
        chk("rst_sel", 8'(sel), 8'h0);
        chk("rst_req_ready", 8'(req_ready), 8'h0);
        reset = 1'b1;
        tick();

        // Single 3-beat packet from requester 2
        req_valid = 4'b0100; din[2] = 2'b11; out_ready = 1'b1;
        tick(); #1;
        chk("single_grant", 8'(grant), 8'h04);
        chk("single_data", 8'(out_data), 8'h3);
        chk("single_last_b1", 8'(out_last), 8'h0);
        tick(); #1;
        chk("single_last_b2", 8'(out_last), 8'h0);
        tick();
        req_last = 4'b0100; #1;
        chk("single_last_b3", 8'(out_last), 8'h1);
        chk("single_xfer_b3", 8'(out_valid & out_ready), 8'h1);
        tick();
        req_valid = '0; #1;
        chk("single_idle", 8'(grant), 8'h0);

        // Pointer now 3: requests 0,1,3 must go to 3
        req_valid = 4'b1011; req_last = 4'b1111;
        tick(); #1;
        chk("ptr3_grant", 8'(grant), 8'h08);
        tick();
        req_valid = '0;
        tick();

        // Round robin with continuous single-beat packets
        req_valid = 4'b1111; req_last = 4'b1111;
        for (int i = 0; i < 9; i++) begin
            tick(); #1;
            chk("rr_grant", 8'(grant), 8'(rr_exp[i]));
        end
        tick();
        req_valid = '0;
        tick();

        // Lock and backpressure on owner 1
        req_valid = 4'b0010; req_last = '0;
        tick(); #1;
        chk("lock_grant", 8'(grant), 8'h02);
        tick();
        req_valid = 4'b1111; out_ready = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_grant", 8'(grant), 8'h02);
            chk("bp_req_ready", 8'(req_ready), 8'h0);
            chk("bp_valid", 8'(out_valid), 8'h1);
            tick();
        end
        out_ready = 1'b1; req_last = 4'b1111; #1;
        chk("bp_resume_ready", 8'(req_ready), 8'h02);
        tick();
        req_valid = '0; #1;
        chk("bp_release", 8'(grant), 8'h0);

        // Owner 3 stalls while requester 0 waits
        req_valid = 4'b1000; req_last = '0;
        tick(); #1;
        chk("stall_grant", 8'(grant), 8'h08);
        tick();
        req_valid = 4'b0001; #1;
        for (int i = 0; i < 2; i++) begin
            chk("stall_valid", 8'(out_valid), 8'h0);
            chk("stall_hold", 8'(grant), 8'h08);
            tick();
        end
        req_valid = 4'b1001; req_last = 4'b1000; #1;
        chk("stall_last_grant", 8'(grant), 8'h08);
        tick(); #1;
        chk("stall_idle", 8'(grant), 8'h0);
        tick(); #1;
        chk("stall_next", 8'(grant), 8'h01);
        req_last = 4'b0001;
        tick();
        req_valid = '0;
        tick();

        // Reset during beat 2 of a packet from requester 2
        din[0] = 2'b01; req_valid = 4'b0100; req_last = '0;
        tick(); #1;
        chk("rmid_grant", 8'(grant), 8'h04);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1; #1;
        chk("rmid_grant0", 8'(grant), 8'h0);
        chk("rmid_sel", 8'(sel), 8'h0);
        chk("rmid_valid", 8'(out_valid), 8'h0);
        chk("rmid_ready", 8'(req_ready), 8'h0);
        chk("rmid_data", 8'(out_data), 8'h1);
        req_valid = 4'b0110;
        tick(); #1;
        chk("rmid_regrant", 8'(grant), 8'h02);
        req_last = 4'b0010;
        tick();
        req_valid = '0; req_last = '0;
        tick();

        // Randomized packets, stalls, backpressure and occasional reset
        for (int i = 0; i < 4; i++) beats[i] = 0;
        acc = '0;
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst_now = ($urandom % 400) == 0;
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) begin
                    beats[i]--;
                    din[i] = 2'($urandom);
                    req_valid[i] = (beats[i] > 0) && ($urandom % 4 != 0);
                end else if (!req_valid[i]) begin
                    if (beats[i] == 0 && $urandom % 3 == 0) begin
                        beats[i] = 1 + int'($urandom % 4);
                        din[i] = 2'($urandom);
                        req_valid[i] = 1'b1;
                    end else if (beats[i] > 0 && $urandom % 2 == 0) begin
                        req_valid[i] = 1'b1;
                    end
                end
                if (rst_now) begin
                    beats[i] = 0;
                    req_valid[i] = 1'b0;
                end
                req_last[i] = (beats[i] == 1);
            end
            reset = !rst_now;
            out_ready = ($urandom % 4) != 0;
            #1;
            acc = rst_now ? 4'b0 : (req_valid & req_ready);
        end
        tick();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
